// File: rtl/data_mem_arbiter_if.sv
// Request/grant bus between the on-board requesters, the data memory and data_mem_arbiter.
// slave = arbiter side, master = requesters plus memory.
interface data_mem_arbiter_if #(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [DATA_W-1:0]         rdata;
  logic                      busy;
  logic                      mem_en;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [DATA_W-1:0]         mem_rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, rdata, busy, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter for the single-port data memory; one transaction at a time (IDLE/ISSUE/RESP).
// Optional per-requester saturating grant counters via DATA_MEM_ARB_STATS_EN.
module data_mem_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32
) (
  input  logic                     CLK100MHZ,
  input  logic                     BTNC,
  data_mem_arbiter_if.slave        bus
`ifdef DATA_MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]    grant_count
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    last_q;
  logic [IDX_W-1:0]    win_q;
  logic                we_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic [IDX_W-1:0]    win_d;
  logic [IDX_W-1:0]    cand;
  logic                found_d;

  always_comb begin
    win_d   = '0;
    found_d = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(last_q) + i) % NUM_REQ);
      if (!found_d && bus.req[cand]) begin
        found_d = 1'b1;
        win_d   = cand;
      end
    end
  end

  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      win_q       <= '0;
      we_q        <= 1'b0;
      gnt_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          gnt_q <= '0;
          if (found_d) begin
            win_q       <= win_d;
            we_q        <= bus.req_we[win_d];
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.req_we[win_d];
            mem_addr_q  <= bus.req_addr[win_d*ADDR_W +: ADDR_W];
            mem_wdata_q <= bus.req_wdata[win_d*DATA_W +: DATA_W];
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          gnt_q       <= NUM_REQ'(1) << win_q;
          state_q     <= RESP;
        end
        RESP: begin
          gnt_q  <= '0;
          if (!we_q) rdata_q <= bus.mem_rdata;
          last_q  <= win_q;
          state_q <= IDLE;
        end
        default: begin
          gnt_q       <= '0;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  // Memory data only arrives in RESP, so the read result bypasses rdata_q to line up with gnt.
  assign bus.rdata     = (state_q == RESP && !we_q) ? bus.mem_rdata : rdata_q;
  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

`ifdef DATA_MEM_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  always_ff @(posedge CLK100MHZ or posedge BTNC) begin
    if (BTNC) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (state_q == RESP && cnt_q[win_q] != 16'hFFFF) begin
      cnt_q[win_q] <= cnt_q[win_q] + 16'd1;
    end
  end

  always_comb begin
    grant_count = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) grant_count[i*16 +: 16] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed, table-driven bench for data_mem_arbiter with a synchronous 1-cycle memory model.
module tb_data_mem_arbiter;
  localparam int NUM_REQ = 5;
  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DATA_MEM_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_count;
`endif

  data_mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK100MHZ  (clk),
    .BTNC       (rst),
    .bus        (bus)
`ifdef DATA_MEM_ARB_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  logic [DATA_W-1:0] mem [1 << ADDR_W];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned idx;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        glitch;
  } vec_t;

  vec_t vecs [8];

  task automatic clear_reqs();
    bus.req       = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic do_txn(input vec_t v);
    @(posedge clk); #1;
    clear_reqs();
    bus.req[v.idx]                      = 1'b1;
    bus.req_we[v.idx]                   = v.we;
    bus.req_addr[v.idx*ADDR_W +: ADDR_W]  = v.addr;
    bus.req_wdata[v.idx*DATA_W +: DATA_W] = v.wdata;
    @(posedge clk);
    if (v.glitch) begin
      #1;
      bus.req_addr[v.idx*ADDR_W +: ADDR_W]  = ~v.addr;
      bus.req_wdata[v.idx*DATA_W +: DATA_W] = ~v.wdata;
    end
    @(negedge clk);
    check("issue_mem_en", 32'(bus.mem_en), 32'd1);
    check("issue_mem_we", 32'(bus.mem_we), 32'(v.we));
    check("issue_mem_addr", 32'(bus.mem_addr), 32'(v.addr));
    if (v.we) check("issue_mem_wdata", bus.mem_wdata, v.wdata);
    check("issue_gnt", 32'(bus.gnt), 32'd0);
    check("issue_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("resp_gnt", 32'(bus.gnt), 32'd1 << v.idx);
    check("resp_rdata", bus.rdata, v.exp_rdata);
    check("resp_mem_en", 32'(bus.mem_en), 32'd0);
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    check("idle_rdata_hold", bus.rdata, v.exp_rdata);
    check("idle_gnt", 32'(bus.gnt), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{2, 1'b1, 10'h005, 32'hDEADBEEF, 32'h0,        1'b1};
    vecs[1] = '{4, 1'b0, 10'h005, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{0, 1'b1, 10'h3FF, 32'h12345678, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1, 1'b1, 10'h000, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b1};
    vecs[4] = '{3, 1'b0, 10'h3FF, 32'h0,        32'h12345678, 1'b0};
    vecs[5] = '{0, 1'b0, 10'h000, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[6] = '{2, 1'b1, 10'h005, 32'h0BADF00D, 32'hA5A5A5A5, 1'b0};
    vecs[7] = '{4, 1'b0, 10'h005, 32'h0,        32'h0BADF00D, 1'b0};

    clear_reqs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);

    // All requesters writing, held high continuously across the reset release.
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W]  = 10'(10'h3F0 + i);
      bus.req_wdata[i*DATA_W +: DATA_W] = 32'(i + 100);
    end
    bus.req    = '1;
    bus.req_we = '1;
    rst        = 1'b0;
    @(posedge clk);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      check("fair_gnt", 32'(bus.gnt), (i % 3 == 2) ? (32'd1 << ((i / 3) % NUM_REQ)) : 32'd0);
    end
    clear_reqs();
    repeat (2) @(posedge clk);

    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int k = 0; k < 8; k++) do_txn(vecs[k]);

    // Wrap and skip: last grant = 3, then requesters 0 and 2 held.
    do_txn('{3, 1'b1, 10'h100, 32'h33333333, 32'h0BADF00D, 1'b0});
    @(posedge clk); #1;
    bus.req    = 5'b00101;
    bus.req_we = 5'b00101;
    bus.req_addr[0 +: ADDR_W]        = 10'h101;
    bus.req_addr[2*ADDR_W +: ADDR_W] = 10'h102;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("wrap_gnt", 32'(bus.gnt), (i == 2) ? 32'd1 : (i == 5) ? 32'd4 : 32'd0);
    end
    clear_reqs();

    // Reset asserted while the read is in ISSUE.
    @(posedge clk); #1;
    bus.req[1]                     = 1'b1;
    bus.req_addr[ADDR_W +: ADDR_W] = 10'h3FF;
    @(posedge clk);
    @(negedge clk);
    check("midop_mem_en_before", 32'(bus.mem_en), 32'd1);
    rst = 1'b1;
    #1;
    check("midop_mem_en", 32'(bus.mem_en), 32'd0);
    check("midop_busy", 32'(bus.busy), 32'd0);
    check("midop_gnt", 32'(bus.gnt), 32'd0);
    check("midop_rdata", bus.rdata, 32'd0);
    @(posedge clk); #1;
    clear_reqs();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midop_no_gnt", 32'(bus.gnt), 32'd0);
    end

`ifdef DATA_MEM_ARB_STATS_EN
    check("stats_rst", grant_count[31:0], 32'd0);
    do_txn('{1, 1'b1, 10'h200, 32'h1, 32'h0, 1'b0});
    check("stats_one", 32'(grant_count[16 +: 16]), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
